stereo_sample_sequencer: RTL and testbench

Front-end controller that shares one sign-extension/alignment stage between the left and right 16-bit input channels. It buffers one sample per channel and arbitrates between them round-robin. Each granted sample is converted to the 40-bit accumulator format (sign in [39:32], sample in [31:16], zeros in [15:0]). The result goes to the downstream filter/MAC core over a valid/ready handshake, tagged with its channel.

---
 rtl/stereo_sample_sequencer.sv | 124 ++++++++++++
 tb/tb_stereo_sample_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_sample_sequencer.sv
// Stereo front-end: buffers one L and one R sample, grants them round-robin and sign-extends into the 40-bit accumulator format.
// Optional macro SEQ_OVERRUN_COUNT_EN adds saturating 8-bit drop counters ovcntL/ovcntR.
module stereo_sample_sequencer (
  input  logic        Sclk,
  input  logic        Reset,
  input  logic        en,
  input  logic [15:0] inL,
  input  logic        inL_valid,
  input  logic [15:0] inR,
  input  logic        inR_valid,
  output logic [39:0] out_data,
  output logic        out_chan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        overrunL,
  output logic        overrunR
`ifdef SEQ_OVERRUN_COUNT_EN
  ,
  output logic [7:0]  ovcntL,
  output logic [7:0]  ovcntR
`endif
);

  // Handshake: a transfer happens on a posedge where out_valid && out_ready;
  // out_data/out_chan/out_valid stay stable from grant until that edge.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state, state_next;
  logic [15:0] hold_l, hold_r, sel_sample;
  logic        pend_l, pend_r, got_l, got_r, last_ch;
  logic        grant, grant_ch, accept;
  logic        clr_l, clr_r, load_l, load_r, drop_l, drop_r;
  logic        got_l_next, got_r_next;

  always_ff @(posedge Sclk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && (pend_l || pend_r)) state_next = ISSUE;
      ISSUE:   if (out_valid && out_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On a tie the channel opposite the last grant wins.
  always_comb begin
    grant    = (state == IDLE) && en && (pend_l || pend_r);
    grant_ch = (pend_l && pend_r) ? ~last_ch : pend_r;
    accept   = (state == ISSUE) && out_valid && out_ready;
  end

  // A grant frees its slot on the same edge, so a coincident strobe is captured.
  always_comb begin
    clr_l      = grant && !grant_ch;
    clr_r      = grant && grant_ch;
    load_l     = en && inL_valid && (!pend_l || clr_l);
    load_r     = en && inR_valid && (!pend_r || clr_r);
    drop_l     = en && inL_valid && pend_l && !clr_l;
    drop_r     = en && inR_valid && pend_r && !clr_r;
    sel_sample = grant_ch ? hold_r : hold_l;
    got_l_next = got_l || (accept && !out_chan);
    got_r_next = got_r || (accept && out_chan);
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      hold_l     <= 16'h0;
      hold_r     <= 16'h0;
      pend_l     <= 1'b0;
      pend_r     <= 1'b0;
      overrunL   <= 1'b0;
      overrunR   <= 1'b0;
      out_data   <= 40'h0;
      out_chan   <= 1'b0;
      out_valid  <= 1'b0;
      last_ch    <= 1'b1;
      got_l      <= 1'b0;
      got_r      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load_l) hold_l <= inL;
      if (load_r) hold_r <= inR;
      pend_l   <= load_l || (pend_l && !clr_l);
      pend_r   <= load_r || (pend_r && !clr_r);
      overrunL <= overrunL || drop_l;
      overrunR <= overrunR || drop_r;
      if (grant) begin
        out_data  <= {{8{sel_sample[15]}}, sel_sample, 16'h0000};
        out_chan  <= grant_ch;
        last_ch   <= grant_ch;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (got_l_next && got_r_next) begin
        frame_done <= 1'b1;
        got_l      <= 1'b0;
        got_r      <= 1'b0;
      end else begin
        frame_done <= 1'b0;
        got_l      <= got_l_next;
        got_r      <= got_r_next;
      end
    end
  end

`ifdef SEQ_OVERRUN_COUNT_EN
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      ovcntL <= 8'h00;
      ovcntR <= 8'h00;
    end else begin
      if (drop_l && (ovcntL != 8'hFF)) ovcntL <= ovcntL + 8'h01;
      if (drop_r && (ovcntR != 8'hFF)) ovcntR <= ovcntR + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_stereo_sample_sequencer.sv
// Self-checking bench for stereo_sample_sequencer; honours SEQ_OVERRUN_COUNT_EN when defined.
module tb_stereo_sample_sequencer;

  logic        Sclk = 1'b0;
  logic        Reset, en, inL_valid, inR_valid, out_ready;
  logic [15:0] inL, inR;
  logic [39:0] out_data;
  logic        out_chan, out_valid, frame_done, overrunL, overrunR;
`ifdef SEQ_OVERRUN_COUNT_EN
  logic [7:0]  ovcntL, ovcntR;
`endif

  always #5 Sclk = ~Sclk;

  stereo_sample_sequencer dut (
    .Sclk(Sclk), .Reset(Reset), .en(en),
    .inL(inL), .inL_valid(inL_valid), .inR(inR), .inR_valid(inR_valid),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .overrunL(overrunL), .overrunR(overrunR)
`ifdef SEQ_OVERRUN_COUNT_EN
    , .ovcntL(ovcntL), .ovcntR(ovcntR)
`endif
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [40:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [39:0] ext16(input logic [15:0] s);
    return {{8{s[15]}}, s, 16'h0000};
  endfunction

  // Scoreboard and frame model, sampled on the falling edge.
  logic        mon_on = 1'b0;
  logic        exp_frame = 1'b0;
  logic        exp_frame_n;
  logic        m_got_l = 1'b0, m_got_r = 1'b0;
  logic        prev_stall = 1'b0;
  logic [40:0] prev_out, popped;
  logic        rr_mode = 1'b0, rr_seen = 1'b0;
  int          frame_cnt = 0, cyc = 0, last_frame_cyc = 0;

  always @(negedge Sclk) begin
    cyc++;
    if (mon_on) begin
      check("frame_done", frame_done, exp_frame);
      if (frame_done) begin
        if (rr_mode && rr_seen) check("frame_gap", cyc - last_frame_cyc, 4);
        rr_seen = 1'b1;
        frame_cnt++;
        last_frame_cyc = cyc;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", {out_chan, out_data}, prev_out);
      end
      exp_frame_n = 1'b0;
      if (Reset) begin
        m_got_l = 1'b0;
        m_got_r = 1'b0;
      end else if (out_valid && out_ready) begin
        check("output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          popped = exp_q.pop_front();
          check("out_chan", out_chan, popped[40]);
          check("out_data", out_data, popped[39:0]);
        end
        if (out_chan) m_got_r = 1'b1;
        else          m_got_l = 1'b1;
        if (m_got_l && m_got_r) begin
          exp_frame_n = 1'b1;
          m_got_l = 1'b0;
          m_got_r = 1'b0;
        end
      end
      exp_frame  = exp_frame_n;
      prev_stall = out_valid && !out_ready && !Reset;
      prev_out   = {out_chan, out_data};
    end
  end

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [39:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic strobe(input logic lv, input logic [15:0] ld, input logic rv, input logic [15:0] rd);
    inL = ld; inL_valid = lv;
    inR = rd; inR_valid = rv;
    tick();
    inL_valid = 1'b0;
    inR_valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget, input logic rnd_ready);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic        ch;
    logic [15:0] d;
    Reset = 1'b1; en = 1'b0; out_ready = 1'b0;
    inL = 16'h0; inR = 16'h0; inL_valid = 1'b0; inR_valid = 1'b0;
    tick();
    tick();
    check("rst_out_data", out_data, 40'h0);
    check("rst_out_chan", out_chan, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrunL", overrunL, 1'b0);
    check("rst_overrunR", overrunR, 1'b0);
`ifdef SEQ_OVERRUN_COUNT_EN
    check("rst_ovcntL", ovcntL, 8'h00);
    check("rst_ovcntR", ovcntR, 8'h00);
`endif
    Reset = 1'b0;
    mon_on = 1'b1;

    // Single left sample and its two-cycle latency.
    en = 1'b1; out_ready = 1'b1;
    push(1'b0, 40'hFF80010000);
    strobe(1'b1, 16'h8001, 1'b0, 16'h0);
    check("single_lat1_valid", out_valid, 1'b0);
    tick();
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 40'hFF80010000);
    check("single_chan", out_chan, 1'b0);
    wait_drain(10, 1'b0);
    tick(); tick();

    // Both channels on one edge: L first, then R, one frame pulse.
    do_reset();
    f0 = frame_cnt;
    push(1'b0, 40'h0012340000);
    push(1'b1, 40'hFFFEDC0000);
    strobe(1'b1, 16'h1234, 1'b1, 16'hFEDC);
    wait_drain(20, 1'b0);
    tick(); tick();
    check("both_frame_once", frame_cnt - f0, 1);

    // Backpressure for 10 cycles.
    do_reset();
    out_ready = 1'b0;
    push(1'b0, 40'hFFA5A50000);
    strobe(1'b1, 16'hA5A5, 1'b0, 16'h0);
    tick();
    check("bp_valid", out_valid, 1'b1);
    repeat (10) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 40'hFFA5A50000);
    end
    out_ready = 1'b1;
    tick();
    check("bp_accept", out_valid, 1'b0);
    check("bp_popped", exp_q.size(), 0);

    // Overrun while stalled on an earlier L sample.
    do_reset();
    out_ready = 1'b0;
    push(1'b0, 40'h0070000000);
    strobe(1'b1, 16'h7000, 1'b0, 16'h0);
    strobe(1'b1, 16'h0001, 1'b0, 16'h0);
    check("ovr_first_held", overrunL, 1'b0);
    strobe(1'b1, 16'h0002, 1'b0, 16'h0);
    check("ovr_flagL", overrunL, 1'b1);
    check("ovr_flagR", overrunR, 1'b0);
`ifdef SEQ_OVERRUN_COUNT_EN
    check("ovr_cntL", ovcntL, 8'h01);
    check("ovr_cntR", ovcntR, 8'h00);
`endif
    push(1'b0, 40'h0000010000);
    wait_drain(20, 1'b0);
    check("ovr_sticky", overrunL, 1'b1);

    // Round robin with both slots refilled every cycle.
    do_reset();
    f0 = frame_cnt;
    rr_mode = 1'b1; rr_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 40'h0011110000);
      push(1'b1, 40'h0022220000);
    end
    inL = 16'h1111; inR = 16'h2222;
    inL_valid = 1'b1; inR_valid = 1'b1;
    repeat (9) tick();
    inL_valid = 1'b0; inR_valid = 1'b0;
    wait_drain(20, 1'b0);
    tick(); tick();
    rr_mode = 1'b0;
    check("rr_frames", frame_cnt - f0, 3);
    check("rr_overrunL", overrunL, 1'b1);
    check("rr_overrunR", overrunR, 1'b1);

    // Reset during a stalled issue drops the sample; next tie goes to L.
    do_reset();
    out_ready = 1'b0;
    strobe(1'b1, 16'h5555, 1'b0, 16'h0);
    tick();
    check("rst_issue_valid", out_valid, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_issue_dropped", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      check("rst_no_stale", out_valid, 1'b0);
    end
    push(1'b0, 40'h000A0A0000);
    push(1'b1, 40'h000B0B0000);
    strobe(1'b1, 16'h0A0A, 1'b1, 16'h0B0B);
    wait_drain(20, 1'b0);

    // en low ignores strobes entirely.
    en = 1'b0;
    strobe(1'b1, 16'h1111, 1'b1, 16'h2222);
    strobe(1'b1, 16'h3333, 1'b1, 16'h4444);
    tick();
    check("en0_no_issue", out_valid, 1'b0);
    check("en0_no_ovrL", overrunL, 1'b0);
    check("en0_no_ovrR", overrunR, 1'b0);

    // en falls mid-issue: transfer completes, pending R waits for en.
    en = 1'b1; out_ready = 1'b0;
    push(1'b0, 40'h0043210000);
    strobe(1'b1, 16'h4321, 1'b0, 16'h0);
    strobe(1'b0, 16'h0, 1'b1, 16'h1357);
    check("enfall_issue", out_valid, 1'b1);
    en = 1'b0; out_ready = 1'b1;
    tick();
    check("enfall_done", out_valid, 1'b0);
    repeat (3) begin
      tick();
      check("enfall_idle", out_valid, 1'b0);
    end
    push(1'b1, 40'h0013570000);
    en = 1'b1;
    wait_drain(10, 1'b0);

    // Random single-channel traffic with random backpressure.
    for (int i = 0; i < 20; i++) begin
      ch = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      push(ch, ext16(d));
      out_ready = 1'($urandom_range(0, 1));
      if (ch) strobe(1'b0, 16'h0, 1'b1, d);
      else    strobe(1'b1, d, 1'b0, 16'h0);
      wait_drain(60, 1'b1);
      tick();
    end

    tick(); tick();
    check("end_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
